intc_sync: RTL and testbench

INTC_SYNC -- requirements
Module: intc_sync

---
 rtl/intc_sync.sv | 184 ++++++++++++++++++
 tb/tb_intc_sync.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/intc_sync.sv
// rtl/intc_sync.sv - eight-line interrupt controller with input synchronisers, edge/level pending and a request/ack/eoi FSM
module intc_sync #(
    parameter int NIRQ        = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic            ph1,
    input  logic            reset_b,
    input  logic [NIRQ-1:0] irq_in,
    input  logic            cfg_we,
    input  logic [1:0]      cfg_addr,
    input  logic [7:0]      cfg_wdata,
    output logic [7:0]      cfg_rdata,
    output logic [NIRQ-1:0] interrupts,
    output logic            irq_req,
    output logic [2:0]      irq_id,
    input  logic            irq_ack,
    input  logic            irq_eoi
);

    localparam logic [1:0] ADDR_MASK    = 2'd0;
    localparam logic [1:0] ADDR_PENDING = 2'd1;
    localparam logic [1:0] ADDR_MODE    = 2'd2;
    localparam logic [1:0] ADDR_STATUS  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_REQ     = 2'b01,
        ST_SERVICE = 2'b10
    } state_t;

    state_t          state;

    // Synchroniser chain; only the last stage is ever looked at.
    logic [NIRQ-1:0] sync_q [SYNC_STAGES];
    logic [NIRQ-1:0] sync_line;
    logic [NIRQ-1:0] sync_prev;
    logic [NIRQ-1:0] rise;

    // Configuration registers.
    logic [NIRQ-1:0] mask;
    logic [NIRQ-1:0] pending;
    logic [NIRQ-1:0] mode;

    // Next-state helpers.
    logic [NIRQ-1:0] mask_nxt;
    logic [NIRQ-1:0] pending_nxt;
    logic [NIRQ-1:0] w1c;
    logic [NIRQ-1:0] ack_clr;
    logic [NIRQ-1:0] active;
    logic            ack_fire;
    logic [2:0]      prio_id;
    logic            req_still_active;

    assign sync_line = sync_q[SYNC_STAGES-1];
    assign rise      = sync_line & ~sync_prev;
    assign active    = pending & mask;
    assign ack_fire  = (state == ST_REQ) && irq_ack;

    // Shift raw lines through the synchroniser and keep the previous synchronised value for edge detection.
    always_ff @(posedge ph1 or negedge reset_b) begin
        if (!reset_b) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            sync_prev <= '0;
        end else begin
            sync_q[0] <= irq_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            sync_prev <= sync_line;
        end
    end

    // Decode the write strobes and the acknowledge clear for this cycle.
    always_comb begin
        w1c      = '0;
        mask_nxt = mask;
        ack_clr  = '0;
        if (cfg_we && (cfg_addr == ADDR_PENDING)) begin
            w1c = cfg_wdata;
        end
        if (cfg_we && (cfg_addr == ADDR_MASK)) begin
            mask_nxt = cfg_wdata;
        end
        if (ack_fire) begin
            ack_clr[irq_id] = 1'b1;
        end
    end

    // Edge bits latch and clear (a fresh edge beats any clear); level bits just track the synchronised line.
    always_comb begin
        pending_nxt = '0;
        for (int i = 0; i < NIRQ; i++) begin
            if (mode[i]) begin
                pending_nxt[i] = rise[i] | (pending[i] & ~w1c[i] & ~ack_clr[i]);
            end else begin
                pending_nxt[i] = sync_line[i];
            end
        end
    end

    // Fixed priority: scan from the top so the lowest active index wins.
    always_comb begin
        prio_id = '0;
        for (int i = NIRQ - 1; i >= 0; i--) begin
            if (active[i]) begin
                prio_id = 3'(i);
            end
        end
    end

    // A request is withdrawn the moment its pending bit is about to drop; a mask change is seen a cycle later.
    assign req_still_active = pending_nxt[irq_id] & mask[irq_id];

    // Register file and the registered interrupts vector, which reflects this edge's updates.
    always_ff @(posedge ph1 or negedge reset_b) begin
        if (!reset_b) begin
            mask       <= '0;
            pending    <= '0;
            mode       <= '0;
            interrupts <= '0;
        end else begin
            mask       <= mask_nxt;
            pending    <= pending_nxt;
            interrupts <= pending_nxt & mask_nxt;
            if (cfg_we && (cfg_addr == ADDR_MODE)) begin
                mode <= cfg_wdata;
            end
        end
    end

    // Request/acknowledge/end-of-interrupt sequencing with registered irq_req and irq_id.
    always_ff @(posedge ph1 or negedge reset_b) begin
        if (!reset_b) begin
            state   <= ST_IDLE;
            irq_req <= 1'b0;
            irq_id  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|active) begin
                        state   <= ST_REQ;
                        irq_req <= 1'b1;
                        irq_id  <= prio_id;
                    end
                end
                ST_REQ: begin
                    // Ack takes precedence over eoi and over a simultaneous drop.
                    if (irq_ack) begin
                        state   <= ST_SERVICE;
                        irq_req <= 1'b0;
                    end else if (!req_still_active) begin
                        state   <= ST_IDLE;
                        irq_req <= 1'b0;
                    end
                end
                ST_SERVICE: begin
                    irq_req <= 1'b0;
                    if (irq_eoi) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    irq_req <= 1'b0;
                end
            endcase
        end
    end

    // Combinational register readback.
    always_comb begin
        cfg_rdata = '0;
        case (cfg_addr)
            ADDR_MASK:    cfg_rdata = mask;
            ADDR_PENDING: cfg_rdata = pending;
            ADDR_MODE:    cfg_rdata = mode;
            ADDR_STATUS:  cfg_rdata = {state, 3'b000, irq_id};
            default:      cfg_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_intc_sync.sv
// tb/tb_intc_sync.sv - directed scoreboard bench for intc_sync
module tb_intc_sync;

    logic       ph1;
    logic       reset_b;
    logic [7:0] irq_in;
    logic       cfg_we;
    logic [1:0] cfg_addr;
    logic [7:0] cfg_wdata;
    logic [7:0] cfg_rdata;
    logic [7:0] interrupts;
    logic       irq_req;
    logic [2:0] irq_id;
    logic       irq_ack;
    logic       irq_eoi;

    int checks = 0;
    int errors = 0;

    string      tag_q[$];
    logic [7:0] exp_q[$];

    intc_sync #(.NIRQ(8), .SYNC_STAGES(2)) dut (
        .ph1        (ph1),
        .reset_b    (reset_b),
        .irq_in     (irq_in),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_wdata  (cfg_wdata),
        .cfg_rdata  (cfg_rdata),
        .interrupts (interrupts),
        .irq_req    (irq_req),
        .irq_id     (irq_id),
        .irq_ack    (irq_ack),
        .irq_eoi    (irq_eoi)
    );

    initial ph1 = 1'b0;
    always #5 ph1 = ~ph1;

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    task automatic tick();
        @(posedge ph1);
        #1;
    endtask

    task automatic push(input string tag, input logic [7:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic pop_check(input logic [7:0] obs);
        string      t;
        logic [7:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty observed %h expected none", obs);
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s observed %h expected %h", t, obs, e);
            end
        end
    endtask

    task automatic rd(input logic [1:0] addr, output logic [7:0] v);
        cfg_addr = addr;
        #1;
        v = cfg_rdata;
    endtask

    task automatic chk_reg(input string tag, input logic [1:0] addr, input logic [7:0] e);
        logic [7:0] v;
        push(tag, e);
        rd(addr, v);
        pop_check(v);
    endtask

    task automatic chk_req(input string tag, input logic e);
        push(tag, {7'b0, e});
        pop_check({7'b0, irq_req});
    endtask

    task automatic chk_int(input string tag, input logic [7:0] e);
        push(tag, e);
        pop_check(interrupts);
    endtask

    task automatic cfg_write(input logic [1:0] addr, input logic [7:0] data);
        cfg_we    = 1'b1;
        cfg_addr  = addr;
        cfg_wdata = data;
        tick();
        cfg_we    = 1'b0;
        cfg_wdata = 8'h00;
    endtask

    task automatic pulse_ack();
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
    endtask

    task automatic pulse_eoi();
        irq_eoi = 1'b1;
        tick();
        irq_eoi = 1'b0;
    endtask

    initial begin
        reset_b   = 1'b0;
        irq_in    = 8'h00;
        cfg_we    = 1'b0;
        cfg_addr  = 2'd0;
        cfg_wdata = 8'h00;
        irq_ack   = 1'b0;
        irq_eoi   = 1'b0;

        // Reset state.
        #2;
        chk_req("rst_req", 1'b0);
        chk_int("rst_int", 8'h00);
        chk_reg("rst_mask", 2'd0, 8'h00);
        chk_reg("rst_pend", 2'd1, 8'h00);
        chk_reg("rst_mode", 2'd2, 8'h00);
        chk_reg("rst_status", 2'd3, 8'h00);
        tick();
        tick();
        reset_b = 1'b1;
        tick();
        chk_req("post_rst_req", 1'b0);

        // Edge path on line 1.
        cfg_write(2'd0, 8'h02);
        cfg_write(2'd2, 8'h02);
        push("edge_pend", 8'h02);
        push("edge_int", 8'h02);
        irq_in[1] = 1'b1;
        tick();
        tick();
        irq_in[1] = 1'b0;
        tick();
        begin
            logic [7:0] v;
            rd(2'd1, v);
            pop_check(v);
            pop_check(interrupts);
        end
        chk_req("edge_req_lat", 1'b0);
        tick();
        chk_req("edge_req", 1'b1);
        chk_reg("edge_status_req", 2'd3, 8'h41);
        pulse_ack();
        chk_reg("edge_pend_ack", 2'd1, 8'h00);
        chk_reg("edge_status_srv", 2'd3, 8'h81);
        chk_req("edge_req_srv", 1'b0);
        pulse_eoi();
        chk_reg("edge_status_eoi", 2'd3, 8'h01);

        // Priority between lines 0 and 1; ack with eoi acts as ack only.
        cfg_write(2'd0, 8'h03);
        cfg_write(2'd2, 8'h03);
        irq_in[1:0] = 2'b11;
        tick();
        tick();
        irq_in[1:0] = 2'b00;
        tick();
        chk_reg("prio_pend", 2'd1, 8'h03);
        tick();
        chk_reg("prio_first", 2'd3, 8'h40);
        irq_ack = 1'b1;
        irq_eoi = 1'b1;
        tick();
        irq_ack = 1'b0;
        chk_reg("prio_ackeoi", 2'd3, 8'h80);
        chk_reg("prio_pend_ack", 2'd1, 8'h02);
        tick();
        irq_eoi = 1'b0;
        chk_reg("prio_idle", 2'd3, 8'h00);
        tick();
        chk_reg("prio_second", 2'd3, 8'h41);
        pulse_ack();
        pulse_eoi();
        chk_reg("prio_done", 2'd3, 8'h01);

        // Level line 2 withdrawn before ack.
        cfg_write(2'd2, 8'h00);
        cfg_write(2'd0, 8'h04);
        irq_in[2] = 1'b1;
        tick();
        tick();
        tick();
        chk_reg("lvl_pend", 2'd1, 8'h04);
        chk_int("lvl_int", 8'h04);
        tick();
        chk_reg("lvl_status_req", 2'd3, 8'h42);
        irq_in[2] = 1'b0;
        push("lvl_req_f2", 8'h01);
        push("lvl_req_f3", 8'h00);
        tick();
        tick();
        pop_check({7'b0, irq_req});
        tick();
        pop_check({7'b0, irq_req});
        chk_reg("lvl_status_idle", 2'd3, 8'h02);
        pulse_ack();
        chk_reg("lvl_ack_ignored", 2'd3, 8'h02);
        chk_req("lvl_req_after_ack", 1'b0);

        // Set wins over W1C on line 3.
        cfg_write(2'd0, 8'h00);
        cfg_write(2'd2, 8'h08);
        irq_in[3] = 1'b1;
        tick();
        tick();
        tick();
        chk_reg("sw_pend_set", 2'd1, 8'h08);
        irq_in[3] = 1'b0;
        cfg_write(2'd1, 8'h08);
        chk_reg("sw_w1c_clear", 2'd1, 8'h00);
        tick();
        irq_in[3] = 1'b1;
        tick();
        tick();
        chk_reg("sw_pend_pre", 2'd1, 8'h00);
        cfg_write(2'd1, 8'h08);
        chk_reg("sw_set_wins", 2'd1, 8'h08);
        irq_in[3] = 1'b0;
        cfg_write(2'd1, 8'h08);

        // Masking on line 4.
        cfg_write(2'd2, 8'h18);
        irq_in[4] = 1'b1;
        tick();
        tick();
        irq_in[4] = 1'b0;
        tick();
        chk_reg("msk_pend", 2'd1, 8'h10);
        chk_int("msk_int_masked", 8'h00);
        tick();
        tick();
        chk_req("msk_no_req", 1'b0);
        cfg_write(2'd0, 8'h10);
        chk_int("msk_int_open", 8'h10);
        chk_req("msk_req_lat", 1'b0);
        tick();
        chk_req("msk_req", 1'b1);
        chk_reg("msk_status_req", 2'd3, 8'h44);
        pulse_ack();
        chk_reg("msk_status_srv", 2'd3, 8'h84);

        // Asynchronous reset in the middle of SERVICE.
        cfg_write(2'd0, 8'h18);
        irq_in[3] = 1'b1;
        tick();
        tick();
        tick();
        chk_int("pre_rst_int", 8'h08);
        reset_b = 1'b0;
        #1;
        chk_req("arst_req", 1'b0);
        chk_int("arst_int", 8'h00);
        chk_reg("arst_status", 2'd3, 8'h00);
        chk_reg("arst_mask", 2'd0, 8'h00);
        tick();
        reset_b = 1'b1;
        tick();
        chk_req("arst_post_req", 1'b0);
        chk_reg("arst_post_pend", 2'd1, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
